vx_wb_sched: RTL and testbench

- Weighted round-robin scheduler sharing the single register-file writeback port among NUM_REQS commit streams (ld, fpu, alu, csr, gpu, sau).
- Grants one stream per cycle, holds ownership for up to a programmed burst weight and registers the winner into a one-entry output stage.
- A per-stream wait counter forces an override grant when any stream starves.
- Sits between the execute-unit commit interfaces and the writeback pipe register.

---
 rtl/vx_wb_sched.sv | 126 ++++++++++++
 tb/tb_vx_wb_sched.sv | 214 +++++++++++++++++++++
 2 files changed

// File: rtl/vx_wb_sched.sv
// Weighted round-robin scheduler for the shared register-file writeback port.
// Includes starvation override and a one-entry registered output stage.
module vx_wb_sched #(
  parameter int unsigned NUM_REQS = 6,
  parameter int unsigned DATAW    = 1100,
  parameter int unsigned WEIGHTW  = 3,
  parameter int unsigned STARVEW  = 4
) (
  input  logic                          clk,
  input  logic                          reset,
  input  logic [NUM_REQS-1:0]           valid_in,
  input  logic [NUM_REQS*DATAW-1:0]     data_in,
  output logic [NUM_REQS-1:0]           ready_in,
  input  logic [NUM_REQS*WEIGHTW-1:0]   weight_in,
  output logic                          valid_out,
  output logic [DATAW-1:0]              data_out,
  output logic [$clog2(NUM_REQS)-1:0]   grant_idx,
  input  logic                          ready_out,
  output logic                          starve_evt
);

  localparam int unsigned IdxW = $clog2(NUM_REQS);
  localparam logic [STARVEW-1:0] StarveMax = '1;

  logic [IdxW-1:0]    owner_q;
  logic [WEIGHTW-1:0] credit_q;
  logic [STARVEW-1:0] wait_q [NUM_REQS];

  logic               en;
  logic               gnt_any;
  logic               gnt_ovr;
  logic               gnt_hold;
  logic [IdxW-1:0]    gnt_idx;
  logic [NUM_REQS-1:0] xfer;
  logic [DATAW-1:0]   win_data;
  logic [WEIGHTW-1:0] win_weight;

  assign en = ~valid_out | ready_out;

  // Priority: starvation override, then burst hold, then round-robin from owner+1.
  always_comb begin
    int idx;
    gnt_any  = 1'b0;
    gnt_ovr  = 1'b0;
    gnt_hold = 1'b0;
    gnt_idx  = '0;
    idx      = 0;
    for (int i = NUM_REQS - 1; i >= 0; i--) begin
      if (valid_in[i] && wait_q[i] == StarveMax) begin
        gnt_ovr = 1'b1;
        gnt_idx = IdxW'(i);
      end
    end
    if (gnt_ovr) begin
      gnt_any = 1'b1;
    end else if (valid_in[owner_q] && credit_q != '0) begin
      gnt_any  = 1'b1;
      gnt_hold = 1'b1;
      gnt_idx  = owner_q;
    end else begin
      // Descending scan so the nearest stream after the owner is assigned last.
      for (int k = NUM_REQS; k >= 1; k--) begin
        idx = int'(owner_q) + k;
        if (idx >= int'(NUM_REQS)) idx = idx - int'(NUM_REQS);
        if (valid_in[IdxW'(idx)]) begin
          gnt_any = 1'b1;
          gnt_idx = IdxW'(idx);
        end
      end
    end
  end

  always_comb begin
    win_data   = '0;
    win_weight = '0;
    ready_in   = '0;
    for (int i = 0; i < int'(NUM_REQS); i++) begin
      if (gnt_idx == IdxW'(i)) begin
        win_data   = data_in[i*DATAW +: DATAW];
        win_weight = weight_in[i*WEIGHTW +: WEIGHTW];
      end
    end
    if (reset && en && gnt_any) ready_in[gnt_idx] = 1'b1;
  end

  assign xfer = valid_in & ready_in;

  always_ff @(posedge clk) begin
    if (!reset) begin
      valid_out  <= 1'b0;
      data_out   <= '0;
      grant_idx  <= '0;
      starve_evt <= 1'b0;
      owner_q    <= IdxW'(NUM_REQS - 1);
      credit_q   <= '0;
      for (int i = 0; i < int'(NUM_REQS); i++) wait_q[i] <= '0;
    end else begin
      starve_evt <= 1'b0;
      if (en) begin
        if (gnt_any) begin
          valid_out <= 1'b1;
          data_out  <= win_data;
          grant_idx <= gnt_idx;
          if (gnt_ovr) begin
            starve_evt <= 1'b1;
          end else if (gnt_hold) begin
            credit_q <= credit_q - 1'b1;
          end else begin
            owner_q  <= gnt_idx;
            credit_q <= (win_weight == '0) ? '0 : win_weight - 1'b1;
          end
        end else begin
          valid_out <= 1'b0;
        end
      end
      for (int i = 0; i < int'(NUM_REQS); i++) begin
        if (xfer[i] || !valid_in[i]) begin
          wait_q[i] <= '0;
        end else if (wait_q[i] != StarveMax) begin
          wait_q[i] <= wait_q[i] + 1'b1;
        end
      end
    end
  end

endmodule

// File: tb/tb_vx_wb_sched.sv
// Scoreboard bench for vx_wb_sched: a queue-based reference model predicts every
// accepted payload; a negedge monitor pops and compares whenever an output appears.
module tb_vx_wb_sched;

  localparam int N   = 6;
  localparam int DW  = 40;
  localparam int WW  = 3;
  localparam int SW  = 4;
  localparam int MAX = (1 << SW) - 1;

  typedef struct {
    logic [DW-1:0] data;
    int            idx;
    bit            starve;
  } exp_t;

  logic            clk;
  logic            rst_n;
  logic [N-1:0]    valid_in;
  logic [N*DW-1:0] data_in;
  logic [N-1:0]    ready_in;
  logic [N*WW-1:0] weight_in;
  logic            valid_out;
  logic [DW-1:0]   data_out;
  logic [2:0]      grant_idx;
  logic            ready_out;
  logic            starve_evt;

  vx_wb_sched #(
    .NUM_REQS(N),
    .DATAW   (DW),
    .WEIGHTW (WW),
    .STARVEW (SW)
  ) dut (
    .clk       (clk),
    .reset     (rst_n),
    .valid_in  (valid_in),
    .data_in   (data_in),
    .ready_in  (ready_in),
    .weight_in (weight_in),
    .valid_out (valid_out),
    .data_out  (data_out),
    .grant_idx (grant_idx),
    .ready_out (ready_out),
    .starve_evt(starve_evt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int   checks = 0;
  int   passes = 0;
  exp_t sb_q[$];

  // Reference model state
  int       weights[N];
  int       m_owner;
  int       m_credit;
  bit       m_vo;
  int       m_wait[N];
  logic [N-1:0] exp_ready;
  bit       use_a5;

  function automatic void chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act === exp) passes++;
    else $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
  endfunction

  // Drive one cycle of inputs, advance the model, then wait for the next edge.
  task automatic step(input logic rst, input logic [N-1:0] v, input bit rdy);
    int  win;
    bit  ovr;
    bit  hold;
    bit  en;
    exp_t e;
    rst_n     = rst;
    valid_in  = v;
    ready_out = rdy;
    for (int i = 0; i < N; i++) begin
      data_in[i*DW +: DW]   = DW'({$urandom, $urandom});
      weight_in[i*WW +: WW] = WW'(weights[i]);
    end
    if (use_a5) data_in[DW-1:0] = DW'(8'hA5);
    win = -1; ovr = 0; hold = 0;
    exp_ready = '0;
    if (!rst) begin
      m_vo = 0; m_owner = N - 1; m_credit = 0;
      for (int i = 0; i < N; i++) m_wait[i] = 0;
    end else begin
      en = !m_vo || rdy;
      for (int i = 0; i < N; i++)
        if (win < 0 && v[i] && m_wait[i] == MAX) begin win = i; ovr = 1; end
      if (win < 0 && v[m_owner] && m_credit > 0) begin win = m_owner; hold = 1; end
      for (int k = 1; k <= N; k++)
        if (win < 0 && v[(m_owner + k) % N]) win = (m_owner + k) % N;
      if (en && win >= 0) exp_ready[win] = 1'b1;
      if (en) begin
        if (win >= 0) begin
          e.data = data_in[win*DW +: DW]; e.idx = win; e.starve = ovr;
          sb_q.push_back(e);
          m_vo = 1;
          if (ovr) begin
          end else if (hold) begin
            m_credit--;
          end else begin
            m_owner  = win;
            m_credit = (weights[win] > 1) ? weights[win] - 1 : 0;
          end
        end else begin
          m_vo = 0;
        end
      end
      for (int i = 0; i < N; i++)
        if (!v[i] || exp_ready[i]) m_wait[i] = 0;
        else if (m_wait[i] < MAX) m_wait[i]++;
    end
    @(posedge clk);
    #2;
  endtask

  // Monitor: pop an expectation each time a fresh output is presented.
  initial begin
    bit   new_item;
    exp_t e;
    new_item = 0;
    forever begin
      @(negedge clk);
      chk("ready_in", 64'(ready_in), 64'(exp_ready));
      if (valid_out === 1'b1 && new_item) begin
        if (sb_q.size() == 0) begin
          chk("unexpected_output", 64'(valid_out), 64'd0);
        end else begin
          e = sb_q.pop_front();
          chk("data_out", 64'(data_out), 64'(e.data));
          chk("grant_idx", 64'(grant_idx), 64'(e.idx));
          chk("starve_evt", 64'(starve_evt), 64'(e.starve));
        end
      end else if (rst_n === 1'b1) begin
        chk("starve_evt_idle", 64'(starve_evt), 64'd0);
      end
      new_item = (rst_n === 1'b1) && (!valid_out || ready_out);
    end
  end

  initial begin
    logic [N-1:0] v;
    bit           r;
    logic         rs;
    use_a5 = 0;
    for (int i = 0; i < N; i++) weights[i] = 1;
    rst_n = 1'b0; valid_in = '0; ready_out = 1'b1; data_in = '0; weight_in = '0;
    exp_ready = '0;

    repeat (3) step(1'b0, '0, 1'b1);
    chk("rst_valid_out", 64'(valid_out), 64'd0);
    chk("rst_data_out", 64'(data_out), 64'd0);
    chk("rst_grant_idx", 64'(grant_idx), 64'd0);
    chk("rst_starve_evt", 64'(starve_evt), 64'd0);

    // First transfer after reset release
    use_a5 = 1;
    step(1'b1, 6'b000001, 1'b1);
    use_a5 = 0;
    repeat (2) step(1'b1, '0, 1'b1);

    // Plain round-robin, all weights 1
    step(1'b0, '0, 1'b1);
    repeat (14) step(1'b1, '1, 1'b1);

    // Stream 0 burst weight 3
    weights[0] = 3;
    step(1'b0, '0, 1'b1);
    repeat (14) step(1'b1, '1, 1'b1);

    // Output stall for 5 cycles
    repeat (2) step(1'b1, '1, 1'b1);
    repeat (5) step(1'b1, '1, 1'b0);
    repeat (4) step(1'b1, '1, 1'b1);

    // Heavy weights so low-priority streams starve and get overridden
    for (int i = 0; i < N; i++) weights[i] = 7;
    step(1'b0, '0, 1'b1);
    repeat (60) step(1'b1, '1, 1'b1);
    weights[0] = 7;
    for (int i = 1; i < N; i++) weights[i] = 1;
    step(1'b0, '0, 1'b1);
    repeat (30) step(1'b1, 6'b001001, 1'b1);

    // Reset mid-burst with stream 2 owning
    for (int i = 0; i < N; i++) weights[i] = 1;
    weights[2] = 3;
    step(1'b0, '0, 1'b1);
    step(1'b1, 6'b000100, 1'b1);
    step(1'b0, '1, 1'b1);
    repeat (8) step(1'b1, '1, 1'b1);

    // Randomized traffic
    for (int c = 0; c < 3000; c++) begin
      if ($urandom_range(99) == 0)
        for (int i = 0; i < N; i++) weights[i] = $urandom_range(7);
      v  = N'($urandom);
      r  = ($urandom_range(3) != 0);
      rs = ($urandom_range(199) != 0);
      step(rs, v, r);
    end

    repeat (6) step(1'b1, '0, 1'b1);
    chk("scoreboard_empty", 64'(sb_q.size()), 64'd0);
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
